// File: rtl/control_pkg.sv
// Shared types and encodings for the multi-cycle control unit: state codes,
// opcodes, ALU operation codes, datapath select values and the control word.
package control_pkg;

    typedef logic [3:0] state_t;
    typedef logic [3:0] opcode_t;

    // state     | meaning
    // RST       | just out of reset, all outputs idle
    // FETCH     | read instruction at PC, PC += 2 on mem_ready
    // DECODE    | compute branch/jump target into ALUOut
    // R_EXEC    | A op B (op from funct)
    // R_WB      | write ALUOut to register file
    // I_EXEC    | A + immediate
    // I_WB      | write ALUOut to register file
    // MEM_ADDR  | A + immediate -> effective address
    // MEM_READ  | load from ALUOut address, wait mem_ready
    // MEM_WB    | write loaded data to register file
    // MEM_WRITE | store to ALUOut address, wait mem_ready
    // BRANCH    | A - B, conditional PC load from ALUOut
    // JUMP      | unconditional PC load from ALUOut
    // HALT      | terminal until reset
    localparam state_t S_RST       = 4'd0;
    localparam state_t S_FETCH     = 4'd1;
    localparam state_t S_DECODE    = 4'd2;
    localparam state_t S_R_EXEC    = 4'd3;
    localparam state_t S_R_WB      = 4'd4;
    localparam state_t S_I_EXEC    = 4'd5;
    localparam state_t S_I_WB      = 4'd6;
    localparam state_t S_MEM_ADDR  = 4'd7;
    localparam state_t S_MEM_READ  = 4'd8;
    localparam state_t S_MEM_WB    = 4'd9;
    localparam state_t S_MEM_WRITE = 4'd10;
    localparam state_t S_BRANCH    = 4'd11;
    localparam state_t S_JUMP      = 4'd12;
    localparam state_t S_HALT      = 4'd13;

    localparam opcode_t OP_RTYPE = 4'd0;
    localparam opcode_t OP_ADDI  = 4'd1;
    localparam opcode_t OP_LW    = 4'd2;
    localparam opcode_t OP_SW    = 4'd3;
    localparam opcode_t OP_BEQ   = 4'd4;
    localparam opcode_t OP_BLT   = 4'd5;
    localparam opcode_t OP_J     = 4'd6;
    localparam opcode_t OP_HALT  = 4'd7;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam logic [1:0] SRCA_PC     = 2'd0;
    localparam logic [1:0] SRCA_CONST2 = 2'd1;
    localparam logic [1:0] SRCA_REG_A  = 2'd2;

    localparam logic [1:0] SRCB_REG_B  = 2'd0;
    localparam logic [1:0] SRCB_CONST2 = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;

    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_src;
        logic       pc_write;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_word_t;

    // ADD, all selects 0, all enables 0
    localparam ctrl_word_t CTRL_IDLE = '0;

endpackage

// File: rtl/control_output_decode.sv
// Combinational lookup from FSM state (plus ALU flags and mem_ready where the
// state needs them) to the datapath control word.
module control_output_decode
    import control_pkg::*;
(
    input  state_t     state,
    input  opcode_t    opcode,
    input  logic [2:0] funct,
    input  logic       zero,
    input  logic       negative,
    input  logic       mem_ready,
    output ctrl_word_t ctrl
);

    // Control word per state; unlisted and undefined states stay idle
    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_CONST2;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                // PC and IR only load on the cycle the read completes
                ctrl.pc_write  = mem_ready;
                ctrl.ir_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = SRCA_REG_A;
                ctrl.alu_src_b = SRCB_REG_B;
                ctrl.alu_op    = funct;
            end
            S_I_EXEC, S_MEM_ADDR: begin
                ctrl.alu_src_a = SRCA_REG_A;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_R_WB, S_I_WB: begin
                ctrl.reg_write = 1'b1;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = SRCA_REG_A;
                ctrl.alu_src_b = SRCB_REG_B;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.pc_write  = (opcode == OP_BLT) ? negative : zero;
            end
            S_JUMP: begin
                ctrl.pc_src   = PCSRC_ALUOUT;
                ctrl.pc_write = 1'b1;
            end
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: state register, next-state logic, retired
// instruction counter and sticky halt/illegal flags.
module multicycle_control_unit
    import control_pkg::*;
#(
    parameter int INSTR_W  = 16,
    parameter int OPCODE_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] input_instr,
    input  logic               input_Zero,
    input  logic               input_negative,
    input  logic               input_mem_ready,
    output logic [2:0]         output_ALUOp,
    output logic [1:0]         output_ALUSrcA,
    output logic [1:0]         output_ALUSrcB,
    output logic               output_PCSrc,
    output logic               output_PCWrite,
    output logic               output_IRWrite,
    output logic               output_IorD,
    output logic               output_MemRead,
    output logic               output_MemWrite,
    output logic               output_RegWrite,
    output logic               output_MemtoReg,
    output logic               output_halted,
    output logic               output_illegal,
    output logic [CNT_W-1:0]   output_instr_count
);

    state_t           state_q, state_d;
    opcode_t          opcode;
    logic [2:0]       funct;
    logic             retire, set_halt, set_illegal;
    logic             halted_q, illegal_q;
    logic [CNT_W-1:0] count_q;
    ctrl_word_t       ctrl;
    logic             instr_unused;

    assign opcode = input_instr[INSTR_W-1 -: OPCODE_W];
    assign funct  = input_instr[2:0];
    // Register fields belong to the datapath; only opcode and funct matter here
    assign instr_unused = ^input_instr[INSTR_W-OPCODE_W-1:3];

    // Next state, plus retire and sticky-flag events on the leaving edge
    always_comb begin
        state_d     = S_FETCH;
        retire      = 1'b0;
        set_halt    = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            S_RST:      state_d = S_FETCH;
            S_FETCH:    state_d = input_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_d = S_R_EXEC;
                    OP_ADDI:       state_d = S_I_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BLT: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_HALT: begin
                        state_d  = S_HALT;
                        set_halt = 1'b1;
                        retire   = 1'b1;
                    end
                    default: begin
                        state_d     = S_HALT;
                        set_halt    = 1'b1;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: state_d = input_mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: begin
                state_d = input_mem_ready ? S_FETCH : S_MEM_WRITE;
                retire  = input_mem_ready;
            end
            S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register, retire counter and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RST;
            count_q   <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_q | set_halt;
            illegal_q <= illegal_q | set_illegal;
            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    control_output_decode u_decode (
        .state     (state_q),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (input_Zero),
        .negative  (input_negative),
        .mem_ready (input_mem_ready),
        .ctrl      (ctrl)
    );

    assign output_ALUOp       = ctrl.alu_op;
    assign output_ALUSrcA     = ctrl.alu_src_a;
    assign output_ALUSrcB     = ctrl.alu_src_b;
    assign output_PCSrc       = ctrl.pc_src;
    assign output_PCWrite     = ctrl.pc_write;
    assign output_IRWrite     = ctrl.ir_write;
    assign output_IorD        = ctrl.i_or_d;
    assign output_MemRead     = ctrl.mem_read;
    assign output_MemWrite    = ctrl.mem_write;
    assign output_RegWrite    = ctrl.reg_write;
    assign output_MemtoReg    = ctrl.mem_to_reg;
    assign output_halted      = halted_q;
    assign output_illegal     = illegal_q;
    assign output_instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. A second instance with a 4-bit
// counter shares all inputs so counter wrap-around is reached in few cycles.
module tb_multicycle_control_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        zero_f;
    logic        neg_f;
    logic        mem_ready;

    logic [2:0]  alu_op;
    logic [1:0]  src_a, src_b;
    logic        pc_src, pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg;
    logic        halted, illegal;
    logic [15:0] count;

    logic [2:0]  w_alu_op;
    logic [1:0]  w_src_a, w_src_b;
    logic        w_pc_src, w_pc_write, w_ir_write, w_i_or_d, w_mem_read, w_mem_write;
    logic        w_reg_write, w_mem_to_reg, w_halted, w_illegal;
    logic [3:0]  w_count;

    int n_cmp;
    int n_fail;

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .input_instr(instr), .input_Zero(zero_f),
        .input_negative(neg_f), .input_mem_ready(mem_ready),
        .output_ALUOp(alu_op), .output_ALUSrcA(src_a), .output_ALUSrcB(src_b),
        .output_PCSrc(pc_src), .output_PCWrite(pc_write), .output_IRWrite(ir_write),
        .output_IorD(i_or_d), .output_MemRead(mem_read), .output_MemWrite(mem_write),
        .output_RegWrite(reg_write), .output_MemtoReg(mem_to_reg),
        .output_halted(halted), .output_illegal(illegal), .output_instr_count(count)
    );

    multicycle_control_unit #(.CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .input_instr(instr), .input_Zero(zero_f),
        .input_negative(neg_f), .input_mem_ready(mem_ready),
        .output_ALUOp(w_alu_op), .output_ALUSrcA(w_src_a), .output_ALUSrcB(w_src_b),
        .output_PCSrc(w_pc_src), .output_PCWrite(w_pc_write), .output_IRWrite(w_ir_write),
        .output_IorD(w_i_or_d), .output_MemRead(w_mem_read), .output_MemWrite(w_mem_write),
        .output_RegWrite(w_reg_write), .output_MemtoReg(w_mem_to_reg),
        .output_halted(w_halted), .output_illegal(w_illegal), .output_instr_count(w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack: {ALUOp, SrcA, SrcB, PCSrc, PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg}
    function automatic logic [14:0] cw(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                                       input logic ps, input logic pw, input logic iw, input logic id,
                                       input logic mr, input logic mw, input logic rw, input logic m2r);
        return {op, a, b, ps, pw, iw, id, mr, mw, rw, m2r};
    endfunction

    logic [14:0] obs_cw;
    assign obs_cw = {alu_op, src_a, src_b, pc_src, pc_write, ir_write, i_or_d,
                     mem_read, mem_write, reg_write, mem_to_reg};

    logic [14:0] C_IDLE, C_FETCH_WAIT, C_FETCH_RDY, C_DECODE, C_AIMM, C_WB_ALU;
    logic [14:0] C_MEM_RD, C_MEM_WB, C_MEM_WR, C_JUMP, C_BR_TAKEN, C_BR_NOT;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // FETCH (ready) -> DECODE -> JUMP -> FETCH
    task automatic do_jump();
        instr = 16'h6000;
        step();
        step();
        step();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        C_IDLE       = cw(3'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        C_FETCH_WAIT = cw(3'd0, 2'd0, 2'd1, 0, 0, 0, 0, 1, 0, 0, 0);
        C_FETCH_RDY  = cw(3'd0, 2'd0, 2'd1, 0, 1, 1, 0, 1, 0, 0, 0);
        C_DECODE     = cw(3'd0, 2'd0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0);
        C_AIMM       = cw(3'd0, 2'd2, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0);
        C_WB_ALU     = cw(3'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0);
        C_MEM_RD     = cw(3'd0, 2'd0, 2'd0, 0, 0, 0, 1, 1, 0, 0, 0);
        C_MEM_WB     = cw(3'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 1);
        C_MEM_WR     = cw(3'd0, 2'd0, 2'd0, 0, 0, 0, 1, 0, 1, 0, 0);
        C_JUMP       = cw(3'd0, 2'd0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0);
        C_BR_TAKEN   = cw(3'd1, 2'd2, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0);
        C_BR_NOT     = cw(3'd1, 2'd2, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0);

        rst_n = 1'b1; instr = 16'h0000; zero_f = 1'b0; neg_f = 1'b0; mem_ready = 1'b0;
        #3 rst_n = 1'b0;
        step();
        step();
        chk("reset_ctrl", 32'(obs_cw), 32'(C_IDLE));
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_flags", {30'd0, halted, illegal}, 32'd0);
        rst_n = 1'b1;
        #2;
        chk("rst_state_ctrl", 32'(obs_cw), 32'(C_IDLE));
        step();
        chk("fetch_wait", 32'(obs_cw), 32'(C_FETCH_WAIT));
        step();
        chk("fetch_wait_held", 32'(obs_cw), 32'(C_FETCH_WAIT));

        // ADDI, zero-wait memory
        instr = 16'h1234; mem_ready = 1'b1;
        #1;
        chk("addi_fetch_rdy", 32'(obs_cw), 32'(C_FETCH_RDY));
        step(); chk("addi_decode", 32'(obs_cw), 32'(C_DECODE));
        step(); chk("addi_exec", 32'(obs_cw), 32'(C_AIMM));
        step(); chk("addi_wb", 32'(obs_cw), 32'(C_WB_ALU));
        chk("addi_count_pre", 32'(count), 32'd0);
        step(); chk("addi_count", 32'(count), 32'd1);
        chk("addi_back_fetch", 32'(obs_cw), 32'(C_FETCH_RDY));

        // R-type SLL (funct 5)
        instr = 16'h0125;
        step(); chk("r_decode", 32'(obs_cw), 32'(C_DECODE));
        step(); chk("r_exec", 32'(obs_cw), 32'(cw(3'd5, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0)));
        step(); chk("r_wb", 32'(obs_cw), 32'(C_WB_ALU));
        step(); chk("r_count", 32'(count), 32'd2);

        // LW with three wait cycles in MEM_READ
        instr = 16'h2000;
        step(); step();
        chk("lw_addr", 32'(obs_cw), 32'(C_AIMM));
        mem_ready = 1'b0;
        step(); chk("lw_read_w1", 32'(obs_cw), 32'(C_MEM_RD));
        step(); chk("lw_read_w2", 32'(obs_cw), 32'(C_MEM_RD));
        step(); chk("lw_read_w3", 32'(obs_cw), 32'(C_MEM_RD));
        mem_ready = 1'b1;
        #1;
        chk("lw_read_rdy", 32'(obs_cw), 32'(C_MEM_RD));
        step(); chk("lw_wb", 32'(obs_cw), 32'(C_MEM_WB));
        chk("lw_count_pre", 32'(count), 32'd2);
        step(); chk("lw_count", 32'(count), 32'd3);

        // SW, zero-wait
        instr = 16'h3000;
        step(); step();
        chk("sw_addr", 32'(obs_cw), 32'(C_AIMM));
        step(); chk("sw_write", 32'(obs_cw), 32'(C_MEM_WR));
        step(); chk("sw_count", 32'(count), 32'd4);
        chk("sw_back_fetch", 32'(obs_cw), 32'(C_FETCH_RDY));

        // Branches: flags chosen so the wrong flag would give the wrong answer
        instr = 16'h4000; zero_f = 1'b1; neg_f = 1'b0;
        step(); step(); chk("beq_taken", 32'(obs_cw), 32'(C_BR_TAKEN));
        step(); chk("beq_count", 32'(count), 32'd5);
        instr = 16'h5000; zero_f = 1'b1; neg_f = 1'b0;
        step(); step(); chk("blt_not", 32'(obs_cw), 32'(C_BR_NOT));
        step(); chk("blt_not_count", 32'(count), 32'd6);
        instr = 16'h5000; zero_f = 1'b0; neg_f = 1'b1;
        step(); step(); chk("blt_taken", 32'(obs_cw), 32'(C_BR_TAKEN));
        step();
        instr = 16'h4000; zero_f = 1'b0; neg_f = 1'b1;
        step(); step(); chk("beq_not", 32'(obs_cw), 32'(C_BR_NOT));
        step(); chk("br_count", 32'(count), 32'd8);

        // Jump
        instr = 16'h6000;
        step(); step(); chk("jump", 32'(obs_cw), 32'(C_JUMP));
        step(); chk("jump_count", 32'(count), 32'd9);

        // Counter wrap on the 4-bit instance: 9 -> 15 -> 0
        for (int i = 0; i < 6; i++) do_jump();
        chk("wrap_pre_w", 32'(w_count), 32'd15);
        chk("wrap_pre", 32'(count), 32'd15);
        do_jump();
        chk("wrap_w", 32'(w_count), 32'd0);
        chk("wrap_main", 32'(count), 32'd16);

        // Async reset in the middle of a FETCH wait
        mem_ready = 1'b0;
        #1;
        chk("fetch_before_rst", 32'(obs_cw), 32'(C_FETCH_WAIT));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", 32'(obs_cw), 32'(C_IDLE));
        chk("async_rst_count", 32'(count), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("after_rst_fetch", 32'(obs_cw), 32'(C_FETCH_WAIT));

        // Legal HALT retires once and freezes
        instr = 16'h7000; mem_ready = 1'b1;
        step(); step();
        chk("halt_ctrl", 32'(obs_cw), 32'(C_IDLE));
        chk("halt_flags", {30'd0, halted, illegal}, 32'd2);
        chk("halt_count", 32'(count), 32'd1);
        for (int i = 0; i < 3; i++) begin
            mem_ready = ~mem_ready;
            step();
        end
        chk("halt_stay_ctrl", 32'(obs_cw), 32'(C_IDLE));
        chk("halt_stay_count", 32'(count), 32'd1);

        // Reset clears sticky flags; then illegal opcode 0xA
        rst_n = 1'b0;
        #1;
        chk("rst_clears_flags", {30'd0, halted, illegal}, 32'd0);
        step();
        rst_n = 1'b1;
        instr = 16'hA000; mem_ready = 1'b1;
        step();
        chk("ill_fetch", 32'(obs_cw), 32'(C_FETCH_RDY));
        step(); step();
        chk("ill_flags", {30'd0, halted, illegal}, 32'd3);
        chk("ill_count", 32'(count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            mem_ready = ~mem_ready;
            step();
            chk("ill_stay_ctrl", 32'(obs_cw), 32'(C_IDLE));
        end
        chk("ill_stay_count", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
